// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared types for the cv32e40x EX-stage units.
//   div_opcode_e : operator selected by the M decoder for the divider
//   div_state_e  : control states of the iterative divider
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIVIDE = 2'b01,
    FINISH = 2'b10
  } div_state_e;

endpackage

// File: rtl/cv32e40x_div_iter.sv
// cv32e40x_div_iter: iterative restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle on operand magnitudes, sign fixed up on output.
// Ports:
//   clk, rst_n             core clock, async active-low reset
//   valid_i / ready_o      request handshake (ready_o high only in IDLE)
//   operator_i             DIV_DIV / DIV_DIVU / DIV_REM / DIV_REMU
//   op_a_i / op_b_i        divisor (rs2) / dividend (rs1)
//   kill_i                 abort anything in flight, back to IDLE
//   valid_o / ready_i      result handshake toward writeback
//   result_o               quotient or remainder, 0 while valid_o is low
module cv32e40x_div_iter
  import cv32e40x_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  div_opcode_e operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? neg32(x) : x;
  endfunction

  div_state_e  state_q, state_d;
  div_opcode_e op_q;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;   // dividend magnitude, quotient bits shift in at the LSB
  logic [31:0] dvs_q;   // divisor magnitude
  logic [31:0] rem_q;   // partial remainder
  logic        q_neg_q, r_neg_q;

  logic        signed_op, accept;
  logic [32:0] rem_shift, rem_sub;
  logic        take;
  logic        is_div;
  logic [31:0] q_fix, r_fix;

  assign signed_op = (operator_i == DIV_DIV) || (operator_i == DIV_REM);
  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == FINISH);
  assign accept    = valid_i && ready_o && !kill_i;

  // Partial remainder can need 33 bits before the compare, so keep the carry.
  assign rem_shift = {rem_q, dvd_q[31]};
  assign rem_sub   = rem_shift - {1'b0, dvs_q};
  assign take      = (rem_shift >= {1'b0, dvs_q});

  assign is_div   = (op_q == DIV_DIV) || (op_q == DIV_DIVU);
  assign q_fix    = q_neg_q ? neg32(dvd_q) : dvd_q;
  assign r_fix    = r_neg_q ? neg32(rem_q) : rem_q;
  assign result_o = valid_o ? (is_div ? q_fix : r_fix) : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (valid_i) state_d = (op_a_i == 32'd0) ? FINISH : DIVIDE;
      DIVIDE:  if (cnt_q == 5'd0) state_d = FINISH;
      FINISH:  if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= DIV_DIV;
      cnt_q   <= 5'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      rem_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else if (accept) begin
      op_q  <= operator_i;
      dvs_q <= abs32(op_a_i, signed_op);
      if (op_a_i == 32'd0) begin
        // x/0: quotient all-ones, remainder is the raw dividend; no sign fix-up
        dvd_q   <= 32'hFFFF_FFFF;
        rem_q   <= op_b_i;
        q_neg_q <= 1'b0;
        r_neg_q <= 1'b0;
        cnt_q   <= 5'd0;
      end else begin
        dvd_q   <= abs32(op_b_i, signed_op);
        rem_q   <= 32'd0;
        q_neg_q <= signed_op && (op_a_i[31] ^ op_b_i[31]);
        r_neg_q <= signed_op && op_b_i[31];
        cnt_q   <= 5'd31;
      end
    end else if (state_q == DIVIDE && !kill_i) begin
      rem_q <= take ? rem_sub[31:0] : rem_shift[31:0];
      dvd_q <= {dvd_q[30:0], take};
      if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
    end
  end

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// tb_cv32e40x_div_iter: directed vector table, hand-written kill/reset/
// backpressure sequences and a short random run against a behavioural model.
module tb_cv32e40x_div_iter;
  import cv32e40x_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  div_opcode_e operator_i = DIV_DIV;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  cv32e40x_div_iter dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    div_opcode_e op;
    logic [31:0] a;    // divisor
    logic [31:0] b;    // dividend
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input div_opcode_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (b == 32'h8000_0000) && (a == 32'hFFFF_FFFF);
    sq  = '0;
    sr  = '0;
    if (a != 0 && !ovf) begin
      sq = sb / sa;
      sr = sb % sa;
    end
    case (op)
      DIV_DIVU: return (a == 0) ? 32'hFFFF_FFFF : b / a;
      DIV_REMU: return (a == 0) ? b : b % a;
      DIV_DIV:  return (a == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : sq);
      default:  return (a == 0) ? b : (ovf ? 32'd0 : sr);
    endcase
  endfunction

  // Issue one op, count cycles from the accept edge to valid_o, hold ready_i
  // low for 'stall' cycles checking stability, then complete the handshake.
  task automatic do_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b,
                       input int stall, output logic [31:0] res, output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    valid_i = 1'b1; operator_i = op; op_a_i = a; op_b_i = b; ready_i = 1'b0;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(negedge clk); lat++; end
    res = result_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, valid_o}, 32'd1);
      chk("stall_result", result_o, res);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("post_hs_ready", {31'd0, ready_o}, 32'd1);
    chk("post_hs_valid", {31'd0, valid_o}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_result"}, result_o, 32'd0);
  endtask

  // Start an op, then pull reset asynchronously 'cyc' cycles later.
  task automatic reset_mid(input int cyc);
    @(negedge clk);
    valid_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd3; op_b_i = 32'd1000;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (cyc) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [31:0] spec_v[8];
    int lat, seen;
    div_opcode_e op;

    vecs[0]  = '{DIV_DIVU, 32'd7,          32'd100,        32'd14,         33};
    vecs[1]  = '{DIV_REMU, 32'd7,          32'd100,        32'd2,          33};
    vecs[2]  = '{DIV_DIV,  32'd2,          32'hFFFF_FFF9,  32'hFFFF_FFFD,  33};
    vecs[3]  = '{DIV_REM,  32'd2,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  33};
    vecs[4]  = '{DIV_DIV,  32'd0,          32'd5,          32'hFFFF_FFFF,  1};
    vecs[5]  = '{DIV_REM,  32'd0,          32'd5,          32'd5,          1};
    vecs[6]  = '{DIV_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[7]  = '{DIV_DIV,  32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000,  33};
    vecs[8]  = '{DIV_REM,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
    vecs[9]  = '{DIV_DIVU, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd1,          33};
    vecs[10] = '{DIV_REMU, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd1,          33};
    vecs[11] = '{DIV_REMU, 32'h8000_0001,  32'h8000_0000,  32'h8000_0000,  33};
    vecs[12] = '{DIV_DIV,  32'hFFFF_FFFE,  32'hFFFF_FFF9,  32'd3,          33};
    vecs[13] = '{DIV_REM,  32'hFFFF_FFFE,  32'hFFFF_FFF9,  32'hFFFF_FFFF,  33};
    vecs[14] = '{DIV_DIV,  32'hFFFF_FFFE,  32'd7,          32'hFFFF_FFFD,  33};
    vecs[15] = '{DIV_REM,  32'hFFFF_FFFE,  32'd7,          32'd1,          33};
    vecs[16] = '{DIV_REM,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFB,  1};
    vecs[17] = '{DIV_DIVU, 32'h8000_0000,  32'h7FFF_FFFF,  32'd0,          33};

    spec_v = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
               32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd7};

    #1;
    chk_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Backpressure: result held for 10 stalled cycles.
    do_op(DIV_DIVU, 32'd7, 32'd100, 10, res, lat);
    chk("bp_result", res, 32'd14);

    // Kill + valid while IDLE must not start an op.
    @(negedge clk);
    kill_i = 1'b1; valid_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd3; op_b_i = 32'd9;
    @(negedge clk);
    kill_i = 1'b0; valid_i = 1'b0;
    chk("kill_idle_ready", {31'd0, ready_o}, 32'd1);

    // Kill mid-divide at cycle 12.
    valid_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd7; op_b_i = 32'd100;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (11) @(negedge clk);
    kill_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0; valid_i = 1'b0;
    chk("kill_mid_ready", {31'd0, ready_o}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    chk("kill_no_valid", seen, 32'd0);
    do_op(DIV_REMU, 32'd10, 32'd77, 0, res, lat);
    chk("after_kill_result", res, 32'd7);

    // Kill while FINISH holds under backpressure.
    @(negedge clk);
    valid_i = 1'b1; operator_i = DIV_DIVU; op_a_i = 32'd0; op_b_i = 32'd1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("kfin_valid", {31'd0, valid_o}, 32'd1);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kfin_valid_drop", {31'd0, valid_o}, 32'd0);
    chk("kfin_result_zero", result_o, 32'd0);

    // Async reset while FINISH shows a nonzero result.
    @(negedge clk);
    valid_i = 1'b1; operator_i = DIV_DIV; op_a_i = 32'd0; op_b_i = 32'd1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("rfin_result", result_o, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_fin");
    @(negedge clk);
    rst_n = 1'b1;

    reset_mid(5);
    do_op(DIV_DIV, 32'd3, 32'hFFFF_FFF6, 0, res, lat);
    chk("after_rst_result", res, 32'hFFFF_FFFD);

    // Random operands with stalls and occasional reset pulses.
    for (int n = 0; n < 150; n++) begin
      op = div_opcode_e'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 1) ? spec_v[$urandom_range(0, 7)] : $urandom;
      b  = ($urandom_range(0, 1) == 1) ? spec_v[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
      do_op(op, a, b, $urandom_range(0, 3), res, lat);
      chk($sformatf("rnd%0d_result", n), res, ref_res(op, a, b));
      chk($sformatf("rnd%0d_latency", n), lat, (a == 0) ? 32'd1 : 32'd33);
      if (n % 30 == 29) reset_mid($urandom_range(0, 34));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
